// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers of the EX stage.
// Shift-add multiply or restoring divide, one bit per cycle, sign fix-up in FIX.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic             ReadReq,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivByZero,
  output logic [1:0]       dbg_state
);

  // Handshake: Start is a level held by the pipeline; the op is taken at the
  // first rising edge where the unit is IDLE, and Stall holds the pipeline
  // while it is not. Done/DivByZero pulse for exactly one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 is_div_q, div0_q, neg_q_q, neg_r_q;
  logic                 done_q, dbz_q;

  logic                 accept, arith, signed_op, b_zero;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh, rem_diff;
  logic                 no_borrow;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign accept    = (state_q == IDLE) && Start;
  assign arith     = accept && !Op[2];
  assign signed_op = !Op[0];
  assign b_zero    = (B == '0);
  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  assign abs_a     = (signed_op && A[WIDTH-1]) ? -A : A;
  assign abs_b     = (signed_op && B[WIDTH-1]) ? -B : B;

  // Multiply: low half holds the remaining multiplier bits, high half the sum.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: high half is the partial remainder, low half dividend/quotient.
  assign rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff  = rem_sh - {1'b0, b_q};
  assign no_borrow = (rem_sh >= {1'b0, b_q});
  assign rem_new   = no_borrow ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_next  = {rem_new, acc_q[WIDTH-2:0], no_borrow};

  assign prod_fix  = neg_q_q ? -acc_q : acc_q;
  assign quo_fix   = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (arith) state_d = (Op[1] && b_zero) ? FIX : CALC;
      CALC: if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && Op == 3'b100) begin
            hi_q <= A;
          end else if (accept && Op == 3'b101) begin
            lo_q <= A;
          end else if (arith) begin
            acc_q    <= {{WIDTH{1'b0}}, abs_a};
            b_q      <= abs_b;
            cnt_q    <= '0;
            is_div_q <= Op[1];
            div0_q   <= Op[1] && b_zero;
            neg_q_q  <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r_q  <= signed_op && A[WIDTH-1];
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          acc_q <= is_div_q ? div_next : mul_next;
        end
        FIX: begin
          done_q <= 1'b1;
          if (div0_q) begin
            dbz_q <= 1'b1;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign HiOut     = hi_q;
  assign LoOut     = lo_q;
  assign Busy      = (state_q != IDLE);
  assign Stall     = Busy && (Start || ReadReq);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: scenario tasks plus a Done-triggered scoreboard
// holding {DivByZero, HI, LO} expectations from a behavioural arithmetic model.
module tb_muldiv_sequencer;

  logic        Clk, Reset, Start, ReadReq;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic [31:0] HiOut, LoOut;
  logic        Busy, Stall, Done, DivByZero;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [64:0] exp_q[$];
  logic [31:0] model_hi = 0;
  logic [31:0] model_lo = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .ReadReq(ReadReq),
    .A(A), .B(B), .HiOut(HiOut), .LoOut(LoOut), .Busy(Busy), .Stall(Stall),
    .Done(Done), .DivByZero(DivByZero), .dbg_state(dbg_state)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every Done pulse consumes one expectation.
  always @(negedge Clk) begin
    if (Reset === 1'b1 && Done === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected: Done high with no pending op (hi=%h lo=%h)", HiOut, LoOut);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({DivByZero, HiOut, LoOut} !== e) begin
          n_bad++;
          $display("FAIL result: got dbz=%b hi=%h lo=%h, expected dbz=%b hi=%h lo=%h",
                   DivByZero, HiOut, LoOut, e[64], e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic model_push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'b100: model_hi = a;
      3'b101: model_lo = a;
      3'b000: begin p = sa * sb; {model_hi, model_lo} = p; exp_q.push_back({1'b0, model_hi, model_lo}); end
      3'b001: begin p = {32'b0, a} * {32'b0, b}; {model_hi, model_lo} = p; exp_q.push_back({1'b0, model_hi, model_lo}); end
      3'b010, 3'b011: begin
        if (b == 0) begin
          exp_q.push_back({1'b1, model_hi, model_lo});
        end else begin
          if (op == 3'b010) begin
            q = sa / sb;
            r = sa % sb;
            model_lo = q[31:0];
            model_hi = r[31:0];
          end else begin
            model_lo = a / b;
            model_hi = a % b;
          end
          exp_q.push_back({1'b0, model_hi, model_lo});
        end
      end
      default: ;
    endcase
  endtask

  // Holds Start until the unit is idle, then returns just after the accept edge.
  task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge Clk);
    Start = 1; Op = op; A = a; B = b;
    while (Busy !== 1'b0 && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: Busy=%b still high after %0d cycles, required 0", Busy, guard);
    end
    model_push(op, a, b);
    @(posedge Clk);
    #1;
    Start = 0; Op = 3'b110; A = $urandom; B = $urandom;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge Clk);
      g++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL done_timeout: %0d results pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    Reset = 0; Start = 0; ReadReq = 0; Op = 3'b110; A = 0; B = 0;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if ({Busy, Done, DivByZero, Stall} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b, required 0000", {Busy, Done, DivByZero, Stall});
    end
    n_cmp++;
    if ({HiOut, LoOut} !== 64'h0) begin
      n_bad++; $display("FAIL reset_hilo: got %h, required 0", {HiOut, LoOut});
    end
    Reset = 1;
    @(negedge Clk);
    n_cmp++;
    if (Busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_bad++; $display("FAIL reset_idle: busy=%b state=%0d, required 0/0", Busy, dbg_state);
    end
  endtask

  task automatic test_multu_latency();
    issue_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 34; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (Busy !== (k <= 33)) begin
        n_bad++; $display("FAIL multu_busy cycle %0d: got %b, required %b", k, Busy, (k <= 33));
      end
      n_cmp++;
      if (Done !== (k == 34)) begin
        n_bad++; $display("FAIL multu_done cycle %0d: got %b, required %b", k, Done, (k == 34));
      end
    end
    n_cmp++;
    if (HiOut !== 32'hFFFF_FFFE || LoOut !== 32'h0000_0001) begin
      n_bad++; $display("FAIL multu_value: got %h_%h, required fffffffe_00000001", HiOut, LoOut);
    end
  endtask

  task automatic test_signed_seq();
    issue_op(3'b000, 32'hFFFF_FFFD, 32'd5);
    wait_done();
    n_cmp++;
    if (HiOut !== 32'hFFFF_FFFF || LoOut !== 32'hFFFF_FFF1) begin
      n_bad++; $display("FAIL mult_neg: got %h_%h, required ffffffff_fffffff1", HiOut, LoOut);
    end
    issue_op(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    n_cmp++;
    if (HiOut !== 32'hFFFF_FFFF || LoOut !== 32'hFFFF_FFFD) begin
      n_bad++; $display("FAIL div_neg: got hi=%h lo=%h, required ffffffff/fffffffd", HiOut, LoOut);
    end
    issue_op(3'b011, 32'd100, 32'd7);
    wait_done();
    n_cmp++;
    if (HiOut !== 32'd2 || LoOut !== 32'd14) begin
      n_bad++; $display("FAIL divu: got hi=%0d lo=%0d, required 2/14", HiOut, LoOut);
    end
  endtask

  task automatic test_div0();
    int done_cnt, dbz_cnt;
    issue_op(3'b100, 32'h1234, 32'h0);
    @(negedge Clk);
    n_cmp++;
    if (HiOut !== 32'h1234 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_bad++; $display("FAIL mthi: hi=%h busy=%b done=%b, required 1234/0/0", HiOut, Busy, Done);
    end
    issue_op(3'b101, 32'h5678, 32'h0);
    @(negedge Clk);
    n_cmp++;
    if (LoOut !== 32'h5678 || Busy !== 1'b0) begin
      n_bad++; $display("FAIL mtlo: lo=%h busy=%b, required 5678/0", LoOut, Busy);
    end
    issue_op(3'b011, 32'd7, 32'd0);
    done_cnt = 0; dbz_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (Busy !== (k == 1)) begin
        n_bad++; $display("FAIL div0_busy cycle %0d: got %b, required %b", k, Busy, (k == 1));
      end
      n_cmp++;
      if (Done !== (k == 2) || DivByZero !== (k == 2)) begin
        n_bad++; $display("FAIL div0_pulse cycle %0d: done=%b dbz=%b, required %b", k, Done, DivByZero, (k == 2));
      end
      done_cnt += int'(Done);
      dbz_cnt += int'(DivByZero);
    end
    n_cmp++;
    if (done_cnt != 1 || dbz_cnt != 1) begin
      n_bad++; $display("FAIL div0_count: done=%0d dbz=%0d, required 1/1", done_cnt, dbz_cnt);
    end
    n_cmp++;
    if (HiOut !== 32'h1234 || LoOut !== 32'h5678) begin
      n_bad++; $display("FAIL div0_keep: got %h/%h, required 1234/5678", HiOut, LoOut);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_stall;
    issue_op(3'b010, 32'd1000, 32'hFFFF_FFF9);
    for (int k = 1; k <= 34; k++) begin
      @(negedge Clk);
      exp_stall = (k <= 33) && (Start || ReadReq);
      n_cmp++;
      if (Stall !== exp_stall) begin
        n_bad++; $display("FAIL stall cycle %0d: got %b, required %b", k, Stall, exp_stall);
      end
      if (k == 34) begin
        n_cmp++;
        if (Done !== 1'b1 || Busy !== 1'b0) begin
          n_bad++; $display("FAIL b2b_done: done=%b busy=%b, required 1/0", Done, Busy);
        end
      end
      if (k == 5) begin
        Start = 1; Op = 3'b000; A = 32'hFFFF_FFF4; B = 32'd11;
        model_push(3'b000, 32'hFFFF_FFF4, 32'd11);
      end
      ReadReq = (k >= 10 && k <= 12);
    end
    @(posedge Clk);
    #1;
    Start = 0; Op = 3'b110; A = $urandom; B = $urandom;
    @(negedge Clk);
    n_cmp++;
    if (Busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_accept: busy=%b, required 1", Busy);
    end
    wait_done();
    n_cmp++;
    if (HiOut !== 32'hFFFF_FFFF || LoOut !== 32'hFFFF_FF7C) begin
      n_bad++; $display("FAIL b2b_mult: got %h_%h, required ffffffff_ffffff7c", HiOut, LoOut);
    end
    @(negedge Clk);
    ReadReq = 1;
    #1;
    n_cmp++;
    if (Stall !== 1'b0) begin
      n_bad++; $display("FAIL idle_read_stall: got %b, required 0", Stall);
    end
    ReadReq = 0;
  endtask

  task automatic test_async_reset();
    issue_op(3'b000, 32'h0001_2345, 32'h0000_0100);
    repeat (10) @(negedge Clk);
    #2;
    Reset = 0;
    #1;
    n_cmp++;
    if ({Busy, Done, DivByZero} !== 3'b000 || {HiOut, LoOut} !== 64'h0) begin
      n_bad++; $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, required all 0", Busy, Done, HiOut, LoOut);
    end
    exp_q.delete();
    model_hi = 0; model_lo = 0;
    @(negedge Clk);
    Reset = 1;
    issue_op(3'b000, 32'd6, 32'd7);
    wait_done();
    n_cmp++;
    if (HiOut !== 32'd0 || LoOut !== 32'd42) begin
      n_bad++; $display("FAIL post_reset_mult: got hi=%0d lo=%0d, required 0/42", HiOut, LoOut);
    end
  endtask

  task automatic test_overflow();
    issue_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    n_cmp++;
    if (HiOut !== 32'h0 || LoOut !== 32'h8000_0000) begin
      n_bad++; $display("FAIL div_overflow: got hi=%h lo=%h, required 0/80000000", HiOut, LoOut);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: b = $urandom;
      endcase
      issue_op(op, a, b);
      wait_done();
    end
  endtask

  initial begin
    test_reset();
    test_multu_latency();
    test_signed_seq();
    test_div0();
    test_back_to_back();
    test_async_reset();
    test_overflow();
    test_random();
    repeat (3) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
